// File: rtl/int_pkg.sv
// Shared definitions for the four-source vectored interrupt controller.
// Holds the source count, configuration field offsets, the dispatch FSM
// state type and the lowest-set-bit helper used for priority decisions.
package int_pkg;

   localparam int NUM_IRQ  = 4;
   localparam int GIE_BIT  = 4;   // cfg = {gie, mask[3:0]}
   localparam int MASK_MSB = 3;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_DISPATCH = 1'b1
   } state_e;

   // Isolate the lowest set bit (bit 0 is the highest priority); zero in, zero out.
   function automatic logic [NUM_IRQ-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
      return v & (~v + 4'd1);
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-line synchroniser plus rising-edge detector.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   d     - raw asynchronous input line
//   rise  - one-cycle pulse when the synchronised line goes 0 -> 1
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   dly_r;

   // Synchroniser chain and the extra delay flop used for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         dly_r  <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         dly_r  <= sync_r[SYNC_STAGES-1];
      end
   end

   assign rise = sync_r[SYNC_STAGES-1] & ~dly_r;

endmodule

// File: rtl/int_ctrl.sv
// Four-source vectored interrupt controller with fixed priority and nesting.
// Ports:
//   clk, reset  - clock and asynchronous active-low reset
//   irq_in[3:0] - raw interrupt lines, bit 0 highest priority
//   cfg_we/wd   - configuration write of {gie, mask[3:0]}
//   int_ack     - control-unit acknowledge
//   reti        - return from interrupt, retires the highest-priority in-service bit
//   int_req     - service request (combinational from registers)
//   ie[3:0]     - one-hot vector select, high for the single dispatch cycle
//   int_push    - return-address stack push strobe, same cycle as ie
//   pend_q, isr_q, cfg_q - pending, in-service and configuration registers
module int_ctrl
   import int_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq_in,
   input  logic       cfg_we,
   input  logic [4:0] cfg_wd,
   input  logic       int_ack,
   input  logic       reti,
   output logic       int_req,
   output logic [3:0] ie,
   output logic       int_push,
   output logic [3:0] pend_q,
   output logic [3:0] isr_q,
   output logic [4:0] cfg_q
);

   state_e     state_r, state_nx_s;
   logic [3:0] pend_r, pend_nx_s;
   logic [3:0] isr_r, isr_nx_s;
   logic [4:0] cfg_r;
   logic [3:0] ie_r;
   logic       push_r;
   logic [3:0] rise_s;
   logic [3:0] allow_s;
   logic [3:0] elig_s;
   logic [3:0] sel_s;
   logic       req_s;
   logic       accept_s;

   for (genvar k = 0; k < NUM_IRQ; k++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (irq_in[k]),
         .rise  (rise_s[k])
      );
   end

   // Only sources strictly above the highest-priority active ISR may preempt.
   always_comb begin
      allow_s = 4'hF;
      if (isr_r == 4'd0) begin
         allow_s = 4'hF;
      end else begin
         allow_s = lowest_set(isr_r) - 4'd1;
      end
   end

   assign elig_s   = pend_r & cfg_r[MASK_MSB:0] & allow_s;
   assign sel_s    = lowest_set(elig_s);
   assign req_s    = cfg_r[GIE_BIT] & (|elig_s) & (state_r == S_IDLE);
   assign accept_s = int_ack & req_s;

   // Dispatch FSM next-state: one DISPATCH cycle per accepted acknowledge.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_nx_s = S_DISPATCH;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_DISPATCH: state_nx_s = S_IDLE;
         default:    state_nx_s = S_IDLE;
      endcase
   end

   // Pending/in-service update; a new edge beats the ack clear, reti acts on the old isr.
   always_comb begin
      pend_nx_s = pend_r | rise_s;
      isr_nx_s  = isr_r;
      if (reti) begin
         isr_nx_s = isr_r & ~lowest_set(isr_r);
      end else begin
         isr_nx_s = isr_r;
      end
      if (accept_s) begin
         pend_nx_s = (pend_r & ~sel_s) | rise_s;
         isr_nx_s  = isr_nx_s | sel_s;
      end else begin
         pend_nx_s = pend_r | rise_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Request/config registers and the registered dispatch strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_r <= 4'd0;
         isr_r  <= 4'd0;
         cfg_r  <= 5'd0;
         ie_r   <= 4'd0;
         push_r <= 1'b0;
      end else begin
         pend_r <= pend_nx_s;
         isr_r  <= isr_nx_s;
         if (cfg_we) begin
            cfg_r <= cfg_wd;
         end else begin
            cfg_r <= cfg_r;
         end
         if (accept_s) begin
            ie_r   <= sel_s;
            push_r <= 1'b1;
         end else begin
            ie_r   <= 4'd0;
            push_r <= 1'b0;
         end
      end
   end

   assign int_req  = req_s;
   assign ie       = ie_r;
   assign int_push = push_r;
   assign pend_q   = pend_r;
   assign isr_q    = isr_r;
   assign cfg_q    = cfg_r;

endmodule
